// File: rtl/slow_seq.sv
// slow_seq: holds the accelerator at stock speed around accesses to slow
// peripherals. A qualifying bus cycle (enabled chip select at bus start,
// non-zero SlowTimeout) requests stock speed from the clock switcher. Once
// the switcher acknowledges, the request is held until SlowTimeout ticks of
// TICK_DIV idle CLK cycles have passed with no bus activity. The request is
// then released and the sequencer waits for the acknowledge to drop.
//
// Optional feature: define SLOW_CLKGATE_EN to drive ClockGate during HOLD
// when SlowClockGate was set at the triggering access. Without the macro,
// ClockGate is tied low and SlowClockGate is ignored.
module slow_seq #(
    parameter int TICK_DIV = 1024
) (
    input  logic       CLK,
    input  logic       nPOR,
    input  logic       BACT,
    input  logic       IACKCS,
    input  logic       VIACS,
    input  logic       IWMCS,
    input  logic       SCCCS,
    input  logic       SCSICS,
    input  logic       SndCS,
    input  logic       SlowIACK,
    input  logic       SlowVIA,
    input  logic       SlowIWM,
    input  logic       SlowSCC,
    input  logic       SlowSCSI,
    input  logic       SlowSnd,
    input  logic       SlowClockGate,
    input  logic [3:0] SlowTimeout,
    input  logic       SlowAck,
    output logic       SlowReq,
    output logic       SlowActive,
    output logic       ClockGate
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        REL  = 2'd3
    } state_t;

    state_t          state;
    state_t          nextState;
    logic            BACTr;
    logic [3:0]      Cnt;
    logic [PW-1:0]   Presc;
    logic            Pend;

    logic            BStart;
    logic            Hit;
    logic            Trig;
    logic            tickWrap;
    logic            holdIdle;

    // A bus cycle starts in the first CLK where BACT is seen high.
    assign BStart = BACT && !BACTr;

    assign Hit = (IACKCS & SlowIACK) | (VIACS & SlowVIA) | (IWMCS & SlowIWM) |
                 (SCCCS & SlowSCC) | (SCSICS & SlowSCSI) | (SndCS & SlowSnd);

    // Timeout and enables only matter here, so later changes cannot disturb
    // a hold already in progress.
    assign Trig = BStart && Hit && (SlowTimeout != 4'd0);

    // The prescaler advances only on idle HOLD cycles without a new trigger.
    assign holdIdle = (state == HOLD) && !Trig && !BACT;
    assign tickWrap = holdIdle && (Presc == PRESC_MAX);

    // Next-state selection for the handshake with the clock switcher.
    always_comb begin
        // NOTE: default first so every path assigns nextState and no latch is inferred.
        nextState = state;
        unique case (state)
            IDLE: if (Trig) nextState = REQ;
            REQ:  if (SlowAck) nextState = HOLD;
            // Never leave HOLD while a bus cycle is in flight.
            HOLD: if ((Cnt == 4'd0) && !BACT && !Trig) nextState = REL;
            // A trigger seen during release goes straight back to REQ.
            REL:  if (!SlowAck) nextState = (Pend || Trig) ? REQ : IDLE;
            default: nextState = IDLE;
        endcase
    end

    // State, hold counter, prescaler and registered outputs.
    always_ff @(posedge CLK or negedge nPOR) begin
        if (!nPOR) begin
            // NOTE: async reset drops the request at once; no release handshake.
            state      <= IDLE;
            BACTr      <= 1'b0;
            Cnt        <= 4'd0;
            Presc      <= '0;
            Pend       <= 1'b0;
            SlowReq    <= 1'b0;
            SlowActive <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            state      <= nextState;
            BACTr      <= BACT;
            SlowReq    <= (nextState == REQ) || (nextState == HOLD);
            SlowActive <= (nextState == HOLD);

            // Any trigger reloads the hold length; a tick in the same cycle loses.
            if (Trig) begin
                Cnt <= SlowTimeout;
            end else if (tickWrap && (Cnt != 4'd0)) begin
                Cnt <= Cnt - 4'd1;
            end

            if (!holdIdle || tickWrap) begin
                Presc <= '0;
            end else begin
                Presc <= Presc + 1'b1;
            end

            // Pend remembers a trigger that arrived while the switcher was
            // still acknowledging the previous release.
            if ((state == REL) && SlowAck) begin
                Pend <= Pend || Trig;
            end else begin
                Pend <= 1'b0;
            end
        end
    end

`ifdef SLOW_CLKGATE_EN
    logic gateFlag;
    logic gateNext;

    // The gate choice belongs to whichever trigger last loaded Cnt.
    assign gateNext = Trig ? SlowClockGate : gateFlag;

    // Registered clock gate request, asserted only across HOLD.
    always_ff @(posedge CLK or negedge nPOR) begin
        if (!nPOR) begin
            gateFlag  <= 1'b0;
            ClockGate <= 1'b0;
        end else begin
            gateFlag  <= gateNext;
            ClockGate <= (nextState == HOLD) && gateNext;
        end
    end
`else
    logic unusedSlowClockGate;

    assign unusedSlowClockGate = SlowClockGate;
    assign ClockGate           = 1'b0;
`endif

endmodule

// File: tb/tb_slow_seq.sv
// Bench for slow_seq with TICK_DIV=4: directed scenarios with hand-computed
// expectations, then randomized bus traffic against a cycle model.
module tb_slow_seq;

    localparam int TD = 4;
    localparam int M_IDLE = 0;
    localparam int M_REQ  = 1;
    localparam int M_HOLD = 2;
    localparam int M_REL  = 3;

    logic       CLK;
    logic       nPOR;
    logic       BACT;
    logic       IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS;
    logic       SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd, SlowClockGate;
    logic [3:0] SlowTimeout;
    logic       SlowAck;
    logic       SlowReq, SlowActive, ClockGate;

    int checks   = 0;
    int failures = 0;
    bit cmpOn    = 0;
    bit glitchOn = 0;
    logic [1:0] ackHist = 2'b00;

    // Reference model state
    int mPhase;
    int mTicks;
    int mIdleRun;
    bit mPend, mGate, mPrevBact;
    bit eReq, eActive, eGate;

    int busLeft  = 0;
    int idleLeft = 0;

    slow_seq #(.TICK_DIV(TD)) dut (
        .CLK(CLK), .nPOR(nPOR), .BACT(BACT),
        .IACKCS(IACKCS), .VIACS(VIACS), .IWMCS(IWMCS), .SCCCS(SCCCS),
        .SCSICS(SCSICS), .SndCS(SndCS),
        .SlowIACK(SlowIACK), .SlowVIA(SlowVIA), .SlowIWM(SlowIWM), .SlowSCC(SlowSCC),
        .SlowSCSI(SlowSCSI), .SlowSnd(SlowSnd), .SlowClockGate(SlowClockGate),
        .SlowTimeout(SlowTimeout), .SlowAck(SlowAck),
        .SlowReq(SlowReq), .SlowActive(SlowActive), .ClockGate(ClockGate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPhase = M_IDLE; mTicks = 0; mIdleRun = 0;
        mPend = 0; mGate = 0; mPrevBact = 0;
        eReq = 0; eActive = 0; eGate = 0;
    endtask

    // Advance the model by one CLK edge using the inputs presented to it.
    task automatic modelStep();
        bit hit, trig;
        int nxt;
        if (!nPOR) begin
            modelReset();
            return;
        end
        hit  = (IACKCS && SlowIACK) || (VIACS && SlowVIA) || (IWMCS && SlowIWM) ||
               (SCCCS && SlowSCC) || (SCSICS && SlowSCSI) || (SndCS && SlowSnd);
        trig = BACT && !mPrevBact && hit && (SlowTimeout != 0);
        nxt  = mPhase;
        case (mPhase)
            M_IDLE: if (trig) nxt = M_REQ;
            M_REQ:  if (SlowAck) nxt = M_HOLD;
            M_HOLD: if (mTicks == 0 && !BACT && !trig) nxt = M_REL;
            default: if (!SlowAck) nxt = (mPend || trig) ? M_REQ : M_IDLE;
        endcase
        // One tick per TD consecutive idle CLKs spent holding.
        if (mPhase == M_HOLD && !trig && !BACT) begin
            mIdleRun++;
            if (mIdleRun == TD) begin
                mIdleRun = 0;
                if (mTicks > 0) mTicks--;
            end
        end else begin
            mIdleRun = 0;
        end
        if (trig) begin
            mTicks = int'(SlowTimeout);
            mGate  = SlowClockGate;
        end
        mPend     = (mPhase == M_REL && SlowAck) ? (mPend || trig) : 1'b0;
        mPrevBact = BACT;
        mPhase    = nxt;
        eReq      = (mPhase == M_REQ) || (mPhase == M_HOLD);
        eActive   = (mPhase == M_HOLD);
`ifdef SLOW_CLKGATE_EN
        eGate     = (mPhase == M_HOLD) && mGate;
`else
        eGate     = 1'b0;
`endif
    endtask

    // Switcher stand-in: acknowledge follows SlowReq two cycles later.
    task automatic ackUpdate();
        ackHist = {ackHist[0], SlowReq};
        SlowAck = ackHist[1] || (glitchOn && ackHist == 2'b00 && $urandom_range(0, 7) == 0);
    endtask

    task automatic cyc();
        @(posedge CLK);
        modelStep();
        @(negedge CLK);
        ackUpdate();
    endtask

    task automatic countActive(input int lim, output int n);
        n = 0;
        for (int i = 0; i < lim; i++) begin
            cyc();
            if (SlowActive) n++;
            else break;
        end
    endtask

    task automatic doReset();
        nPOR = 1'b0;
        modelReset();
        cyc();
        cyc();
        nPOR = 1'b1;
        repeat (3) cyc();
    endtask

    task automatic driveRandom();
        if (busLeft > 0) begin
            BACT = 1'b1; busLeft--;
        end else if (idleLeft > 0) begin
            BACT = 1'b0; idleLeft--;
        end else begin
            BACT = 1'b0;
            busLeft  = $urandom_range(1, 6);
            idleLeft = $urandom_range(0, 30);
        end
        IACKCS = 1'($urandom_range(0, 1)); VIACS  = 1'($urandom_range(0, 1));
        IWMCS  = 1'($urandom_range(0, 1)); SCCCS  = 1'($urandom_range(0, 1));
        SCSICS = 1'($urandom_range(0, 1)); SndCS  = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 15) == 0) begin
            SlowIACK = 1'($urandom_range(0, 1)); SlowVIA  = 1'($urandom_range(0, 1));
            SlowIWM  = 1'($urandom_range(0, 1)); SlowSCC  = 1'($urandom_range(0, 1));
            SlowSCSI = 1'($urandom_range(0, 1)); SlowSnd  = 1'($urandom_range(0, 1));
            SlowClockGate = 1'($urandom_range(0, 1));
            SlowTimeout   = 4'($urandom_range(0, 4));
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge CLK) begin
        if (cmpOn) begin
            check("slow_req", SlowReq, eReq);
            check("slow_active", SlowActive, eActive);
            check("clock_gate", ClockGate, eGate);
        end
    end

    initial begin
        int n, m, reqHigh;
        nPOR = 1'b0; BACT = 1'b0; SlowAck = 1'b0;
        IACKCS = 0; VIACS = 0; IWMCS = 0; SCCCS = 0; SCSICS = 0; SndCS = 0;
        SlowIACK = 0; SlowVIA = 0; SlowIWM = 0; SlowSCC = 0; SlowSCSI = 0; SlowSnd = 0;
        SlowClockGate = 0; SlowTimeout = 4'd0;
        modelReset();
        repeat (3) cyc();
        check("reset_req", SlowReq, 0);
        check("reset_active", SlowActive, 0);
        check("reset_gate", ClockGate, 0);
        nPOR  = 1'b1;
        cmpOn = 1'b1;

        // Basic VIA hold: request one cycle after bus start, 12 idle cycles of hold.
        SlowTimeout = 4'd3; SlowVIA = 1'b1; SlowClockGate = 1'b1;
        repeat (2) cyc();
        check("pre_trig_req", SlowReq, 0);
        BACT = 1'b1; VIACS = 1'b1;
        cyc();
        check("req_rise", SlowReq, 1);
        repeat (5) cyc();
        BACT = 1'b0; VIACS = 1'b0;
        countActive(100, n);
        check("hold_len", n, 12);
        // New VIA cycle while releasing with SlowAck still high.
        BACT = 1'b1; VIACS = 1'b1;
        cyc();
        check("rel_pend_low", SlowReq, 0);
        cyc();
        check("rel_reissue", SlowReq, 1);
        cyc();
        BACT = 1'b0; VIACS = 1'b0;
        repeat (40) cyc();
        check("back_idle", SlowReq, 0);

        // Retrigger on the tick that would have emptied the counter.
        doReset();
        BACT = 1'b1; VIACS = 1'b1;
        repeat (6) cyc();
        BACT = 1'b0; VIACS = 1'b0;
        n = 0;
        repeat (11) begin cyc(); if (SlowActive) n++; end
        BACT = 1'b1; VIACS = 1'b1;
        repeat (3) begin cyc(); if (SlowActive) n++; end
        BACT = 1'b0; VIACS = 1'b0;
        countActive(100, m);
        check("hold_no_rel", n, 14);
        check("hold_extend_tail", m, 12);
        repeat (8) cyc();

        // Zero timeout and disabled SCC never request; enabled SCC does.
        doReset();
        SlowTimeout = 4'd0;
        reqHigh = 0;
        BACT = 1'b1; VIACS = 1'b1;
        repeat (4) begin cyc(); if (SlowReq) reqHigh++; end
        BACT = 1'b0; VIACS = 1'b0;
        repeat (6) begin cyc(); if (SlowReq) reqHigh++; end
        SlowTimeout = 4'd3; SlowSCC = 1'b0;
        BACT = 1'b1; SCCCS = 1'b1;
        repeat (4) begin cyc(); if (SlowReq) reqHigh++; end
        BACT = 1'b0; SCCCS = 1'b0;
        repeat (6) begin cyc(); if (SlowReq) reqHigh++; end
        check("no_req_count", reqHigh, 0);
        SlowSCC = 1'b1;
        BACT = 1'b1; SCCCS = 1'b1;
        cyc();
        check("scc_enabled_req", SlowReq, 1);
        repeat (3) cyc();
        BACT = 1'b0; SCCCS = 1'b0;
        repeat (30) cyc();

        // Asynchronous reset in the middle of a hold.
        doReset();
        BACT = 1'b1; VIACS = 1'b1;
        repeat (6) cyc();
        BACT = 1'b0; VIACS = 1'b0;
        repeat (4) cyc();
        check("pre_rst_active", SlowActive, 1);
        #2;
        nPOR = 1'b0;
        modelReset();
        #1;
        check("rst_async_req", SlowReq, 0);
        check("rst_async_active", SlowActive, 0);
        check("rst_async_gate", ClockGate, 0);
        cyc();
        cyc();
        nPOR = 1'b1;
        repeat (10) cyc();
        check("post_rst_idle", SlowReq, 0);

        // Randomized traffic with acknowledge glitches.
        doReset();
        glitchOn = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            driveRandom();
            cyc();
        end
        glitchOn = 1'b0;
        BACT = 1'b0;
        repeat (5) cyc();
        cmpOn = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
